// File: rtl/smart_led_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : smart_led_pkg
// Description : Shared types and default parameter values for the smart LED
//               controller: debounce FSM state encoding and the default
//               channel count, debounce window and dimming counter width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package smart_led_pkg;

  // Pushbutton debounce FSM states
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  localparam int c_N_CH_DEFAULT      = 4;
  localparam int c_DB_CYCLES_DEFAULT = 1000;
  localparam int c_PWM_W_DEFAULT     = 4;

endpackage : smart_led_pkg
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : led_channel
// Description : One LED channel: 2-flop input synchronizers, pushbutton
//               debounce FSM with press-pulse generation, and the on/off
//               state register (manual toggle or remote load).
// Ports       : clk          - system clock
//               rst_n        - internally synchronized active-low reset
//               i_esp        - raw remote on/off command (async)
//               i_mode       - raw mode select, 1 = manual, 0 = remote (async)
//               i_pb         - raw bouncing pushbutton (async)
//               o_led_state  - registered logical on/off state
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module led_channel
  import smart_led_pkg::*;
#(
  parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_esp,
  input  logic i_mode,
  input  logic i_pb,
  output logic o_led_state
);

  localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DB_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [1:0]         r_esp_sync;
  logic [1:0]         r_mode_sync;
  logic [1:0]         r_pb_sync;
  db_state_t          r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_press;
  logic               r_led;

  logic               w_esp;
  logic               w_mode;
  logic               w_pb;
  logic [c_CNT_W-1:0] w_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_esp_sync  <= 2'b00;
      r_mode_sync <= 2'b00;
      r_pb_sync   <= 2'b00;
    end else begin
      r_esp_sync  <= {r_esp_sync[0],  i_esp};
      r_mode_sync <= {r_mode_sync[0], i_mode};
      r_pb_sync   <= {r_pb_sync[0],   i_pb};
    end
  end

  assign w_esp  = r_esp_sync[1];
  assign w_mode = r_mode_sync[1];
  assign w_pb   = r_pb_sync[1];

  // Saturating increment so the counter can never wrap
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  // r_cnt holds the number of consecutive cycles the new level has been seen,
  // including the cycle that left the stable state. The window completes on
  // the edge where that count reaches DB_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (w_pb) begin
            r_state <= WAIT_HI;
            r_cnt   <= c_CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!w_pb) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt >= c_CNT_LAST) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        STABLE_HI: begin
          if (!w_pb) begin
            r_state <= WAIT_LO;
            r_cnt   <= c_CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (w_pb) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt >= c_CNT_LAST) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Remote mode loads ESP every cycle; manual mode toggles on a press.
  // The synchronized mode of the current cycle decides which applies, so a
  // press coincident with a switch to remote is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 1'b0;
    end else if (!w_mode) begin
      r_led <= w_esp;
    end else if (r_press) begin
      r_led <= ~r_led;
    end
  end

  assign o_led_state = r_led;

endmodule : led_channel
`default_nettype wire

// File: rtl/smart_led_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : smart_led_ctrl
// Description : Multi-channel LED controller. Each channel is switched either
//               by a debounced pushbutton (manual) or by a remote command
//               (remote). Optional global PWM dimming of the LED drive.
// Config      : LED_PWM_DIM_EN - when defined, adds BRIGHT_IN and a shared
//               free-running PWM counter gating LED_OUT.
// Ports       : CLK        - system clock
//               CLR_N      - asynchronous active-low reset
//               ESP_IN     - remote on/off per channel (async)
//               SW_MODE_IN - per-channel mode, 1 = manual, 0 = remote (async)
//               PB_IN      - raw pushbutton per channel (async, bouncing)
//               BRIGHT_IN  - global brightness (LED_PWM_DIM_EN only)
//               LED_STATE  - registered on/off state per channel
//               LED_OUT    - LED drive per channel
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module smart_led_ctrl
  import smart_led_pkg::*;
#(
  parameter int N_CH      = c_N_CH_DEFAULT,
  parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT,
  parameter int PWM_W     = c_PWM_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [N_CH-1:0]  ESP_IN,
  input  logic [N_CH-1:0]  SW_MODE_IN,
  input  logic [N_CH-1:0]  PB_IN,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_W-1:0] BRIGHT_IN,
`endif
  output logic [N_CH-1:0]  LED_STATE,
  output logic [N_CH-1:0]  LED_OUT
);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [N_CH-1:0] w_led_state;

  // Reset asserts immediately, releases two clocks after CLR_N rises
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(
      .DB_CYCLES (DB_CYCLES)
    ) u_led_channel (
      .clk         (CLK),
      .rst_n       (w_rst_n),
      .i_esp       (ESP_IN[i]),
      .i_mode      (SW_MODE_IN[i]),
      .i_pb        (PB_IN[i]),
      .o_led_state (w_led_state[i])
    );
  end

  assign LED_STATE = w_led_state;

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_pwm_on;

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + {{(PWM_W-1){1'b0}}, 1'b1};
    end
  end

  // Full-scale brightness is constant on rather than (2^W-1)/2^W duty;
  // zero brightness is naturally constant off since cnt < 0 never holds.
  assign w_pwm_on = (&BRIGHT_IN) | (r_pwm_cnt < BRIGHT_IN);
  assign LED_OUT  = w_led_state & {N_CH{w_pwm_on}};
`else
  assign LED_OUT  = w_led_state;
`endif

endmodule : smart_led_ctrl
`default_nettype wire

// File: tb/tb_smart_led_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_smart_led_ctrl
// Description : Self-checking bench for smart_led_ctrl with N_CH=4,
//               DB_CYCLES=4, PWM_W=4. Table of remote/manual mode vectors
//               plus directed sequences for latency, bounce, retention,
//               reset and dimming.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_smart_led_ctrl;

  localparam int c_N_CH = 4;
  localparam int c_DB   = 4;
  localparam int c_PW   = 4;

  logic             clk = 1'b0;
  logic             clr_n;
  logic [3:0]       esp;
  logic [3:0]       mode;
  logic [3:0]       pb;
  logic [c_PW-1:0]  bright;
  logic [3:0]       led_state;
  logic [3:0]       led_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  smart_led_ctrl #(
    .N_CH      (c_N_CH),
    .DB_CYCLES (c_DB),
    .PWM_W     (c_PW)
  ) dut (
    .CLK        (clk),
    .CLR_N      (clr_n),
    .ESP_IN     (esp),
    .SW_MODE_IN (mode),
    .PB_IN      (pb),
`ifdef LED_PWM_DIM_EN
    .BRIGHT_IN  (bright),
`endif
    .LED_STATE  (led_state),
    .LED_OUT    (led_out)
  );

  typedef struct {
    logic [3:0] esp;
    logic [3:0] mode;
    logic [3:0] exp_state;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change right after a falling edge; outputs are sampled there too
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hi;

    vecs[0] = '{esp: 4'b0100, mode: 4'b1011, exp_state: 4'b0100};
    vecs[1] = '{esp: 4'b1111, mode: 4'b0000, exp_state: 4'b1111};
    vecs[2] = '{esp: 4'b0101, mode: 4'b0000, exp_state: 4'b0101};
    vecs[3] = '{esp: 4'b1010, mode: 4'b0101, exp_state: 4'b1111};
    vecs[4] = '{esp: 4'b0000, mode: 4'b0101, exp_state: 4'b0101};
    vecs[5] = '{esp: 4'b0000, mode: 4'b1111, exp_state: 4'b0101};
    vecs[6] = '{esp: 4'b1111, mode: 4'b1111, exp_state: 4'b0101};
    vecs[7] = '{esp: 4'b0000, mode: 4'b0000, exp_state: 4'b0000};

    clr_n  = 1'b0;
    esp    = 4'b0000;
    mode   = 4'b0000;
    pb     = 4'b0000;
    bright = 4'hF;

    cyc(3);
    check("reset_state", 16'(led_state), 16'h0);
    check("reset_out",   16'(led_out),   16'h0);
    clr_n = 1'b1;
    cyc(5);

    // Manual toggle on channel 0, exact 7-cycle latency
    mode = 4'b1111;
    cyc(4);
    pb = 4'b0001;
    cyc(6);
    check("man_on_early", 16'(led_state), 16'h0);
    cyc(1);
    check("man_on",       16'(led_state), 16'h1);
    cyc(3);
    pb = 4'b0000;
    cyc(10);
    check("man_on_hold",  16'(led_state), 16'h1);

    pb = 4'b0001;
    cyc(6);
    check("man_off_early", 16'(led_state), 16'h1);
    cyc(1);
    check("man_off",       16'(led_state), 16'h0);
    cyc(3);
    pb = 4'b0000;
    cyc(10);

    // Bounce shorter than the window on channel 1
    pb = 4'b0010; cyc(3);
    pb = 4'b0000; cyc(1);
    pb = 4'b0010; cyc(3);
    pb = 4'b0000; cyc(12);
    check("bounce", 16'(led_state), 16'h0);

    // Table: remote load and mode retention
    for (int i = 0; i < 8; i++) begin
      esp  = vecs[i].esp;
      mode = vecs[i].mode;
      cyc(4);
      check($sformatf("vec%0d_state", i), 16'(led_state), 16'(vecs[i].exp_state));
      check($sformatf("vec%0d_out", i),   16'(led_out),   16'(vecs[i].exp_state));
    end

    // Remote latency on channel 2, press ignored in remote mode
    mode = 4'b1011;
    esp  = 4'b0000;
    cyc(4);
    esp = 4'b0100;
    cyc(2);
    check("remote_early", 16'(led_state), 16'h0);
    cyc(1);
    check("remote_on",    16'(led_state), 16'h4);
    pb = 4'b0100;
    cyc(10);
    pb = 4'b0000;
    cyc(10);
    check("remote_press_ignored", 16'(led_state), 16'h4);

    // Switch to manual, remote goes low: state retained until next press
    mode = 4'b1111;
    cyc(4);
    esp = 4'b0000;
    cyc(6);
    check("retain", 16'(led_state), 16'h4);
    pb = 4'b0100;
    cyc(6);
    check("retain_press_early", 16'(led_state), 16'h4);
    cyc(1);
    check("retain_press",       16'(led_state), 16'h0);
    cyc(3);
    pb = 4'b0000;
    cyc(10);

    // Simultaneous presses on two channels
    pb = 4'b0011;
    cyc(6);
    check("simul_early", 16'(led_state), 16'h0);
    cyc(1);
    check("simul",       16'(led_state), 16'h3);
    cyc(3);
    pb = 4'b0000;
    cyc(10);

    // Asynchronous reset mid-debounce, buttons held through release
    esp = 4'b1111;
    pb  = 4'b1111;
    cyc(3);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_rst_state", 16'(led_state), 16'h0);
    check("async_rst_out",   16'(led_out),   16'h0);
    cyc(3);
    clr_n = 1'b1;
    cyc(8);
    check("held_rst_early", 16'(led_state), 16'h0);
    cyc(1);
    check("held_rst_toggle", 16'(led_state), 16'hF);
    cyc(10);
    check("held_rst_once", 16'(led_state), 16'hF);
    pb = 4'b0000;
    cyc(10);
    check("held_rst_release", 16'(led_state), 16'hF);

`ifdef LED_PWM_DIM_EN
    bright = 4'd4;
    cyc(2);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      hi += int'(led_out[0]);
    end
    check("pwm_b4_duty", 16'(hi), 16'd4);

    bright = 4'd15;
    cyc(2);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      hi += int'(led_out[0]);
    end
    check("pwm_b15_duty", 16'(hi), 16'd16);

    bright = 4'd0;
    cyc(2);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      hi += int'(led_out[0]);
    end
    check("pwm_b0_duty", 16'(hi), 16'd0);
`else
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      hi += int'(led_out[0]);
    end
    check("out_follows_state", 16'(hi), 16'd16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_smart_led_ctrl
`default_nettype wire

// File: doc/smart_led_ctrl.md
SMART_LED_CTRL -- requirements
Module: smart_led_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of independent LED channels, 1..16.
REQ-002 Parameter DB_CYCLES, default 1000: pushbutton debounce stability window in clock cycles, minimum 1.
REQ-003 Parameter PWM_W, default 4: dimming counter width in bits.
REQ-004 CLK  input  1  system clock; single clock domain, all state on rising edge.
REQ-005 CLR_N  input  1  reset, asynchronous, active-low.
REQ-006 ESP_IN  input  N_CH  remote on/off command per channel, asynchronous.
REQ-007 SW_MODE_IN  input  N_CH  per-channel mode: 1 = manual (pushbutton), 0 = remote (ESP); asynchronous.
REQ-008 PB_IN  input  N_CH  raw pushbutton per channel, asynchronous, bouncing.
REQ-009 BRIGHT_IN  input  PWM_W  global brightness; present only with LED_PWM_DIM_EN.
REQ-010 LED_STATE  output  N_CH  registered logical on/off state per channel.
REQ-011 LED_OUT  output  N_CH  LED drive per channel.

Function
REQ-012 ESP_IN, SW_MODE_IN and PB_IN shall each pass through a 2-flop synchronizer per bit before use.
REQ-013 Each channel shall debounce its synchronized PB with a 4-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-014 STABLE_LO -> WAIT_HI on sync PB=1; WAIT_HI -> STABLE_HI after DB_CYCLES consecutive cycles at 1; any 0 in WAIT_HI -> STABLE_LO with counter cleared; WAIT_LO/STABLE_LO symmetric.
REQ-015 Debounce counter width shall be $clog2(DB_CYCLES+1); counter shall saturate, never wrap.
REQ-016 A WAIT_HI -> STABLE_HI transition shall produce a one-cycle press pulse; releases shall produce no pulse.
REQ-017 Manual mode: a press pulse shall toggle LED_STATE on the next clock edge; press-to-LED_STATE latency exactly 2 + DB_CYCLES + 1 cycles from first PB_IN=1 sample.
REQ-018 Remote mode: LED_STATE shall load synchronized ESP_IN every cycle; latency 3 cycles from ESP_IN change.
REQ-019 Remote mode: press pulses shall be ignored; debouncer FSM shall continue tracking PB.
REQ-020 Mode change remote -> manual shall retain the current LED_STATE with no glitch; manual -> remote shall follow ESP from the next cycle.
REQ-021 Press pulse coincident with mode change: the synchronized mode value of that cycle shall decide.
REQ-022 Channels shall be fully independent; simultaneous presses on several channels shall all be honoured in the same cycle.

Reset
REQ-023 CLR_N=0 shall asynchronously clear LED_STATE, LED_OUT, synchronizers, debounce counters and the PWM counter; FSMs shall enter STABLE_LO.
REQ-024 Reset asserted mid-debounce or mid-PWM period shall abort it; a button held through reset release shall require a full DB_CYCLES window and produce one toggle.
REQ-025 Reset release shall be synchronized internally with a 2-flop release synchronizer.

Configuration
REQ-026 Macro LED_PWM_DIM_EN defined: shared free-running PWM_W-bit counter; LED_OUT[i] = LED_STATE[i] AND (cnt < BRIGHT_IN), except BRIGHT_IN all-ones forces LED_OUT[i] = LED_STATE[i]; BRIGHT_IN = 0 forces off.
REQ-027 Macro LED_PWM_DIM_EN undefined: BRIGHT_IN port and PWM counter absent; LED_OUT = LED_STATE.

Structure
REQ-028 Shared package smart_led_pkg shall hold the debounce FSM state enum and default parameter constants.
REQ-029 Per-channel logic (synchronizers, debounce FSM, state register) shall be sub-module led_channel, instantiated N_CH times via generate; PWM counter and output gating remain at top level.

Verification (N_CH=4, DB_CYCLES=4, PWM_W=4)
REQ-030 Reset: CLR_N=0 mid-run, all inputs 1 -> LED_STATE=0000, LED_OUT=0000 immediately, no clock needed.
REQ-031 Manual toggle: SW_MODE_IN=1111, PB_IN[0] high 10 cycles -> LED_STATE[0]=1 exactly 7 cycles after rise; second identical press -> 0.
REQ-032 Bounce reject: PB_IN[1] high 3 cycles, low 1, high 3, low -> LED_STATE[1] stays 0.
REQ-033 Remote: SW_MODE_IN[2]=0, ESP_IN[2]=1 -> LED_STATE[2]=1 after 3 cycles; 10-cycle PB_IN[2] press -> no change.
REQ-034 Mode retention: channel 2 on via ESP, SW_MODE_IN[2] -> 1, ESP_IN[2] -> 0 -> LED_STATE[2] stays 1 until next press.
REQ-035 PWM (macro defined): LED_STATE[0]=1, BRIGHT_IN=4 -> LED_OUT[0] high 4 of every 16 cycles; BRIGHT_IN=15 -> constant 1; BRIGHT_IN=0 -> constant 0.
